// File: rtl/bus_source_arbiter_if.sv
// Bus-source request/grant bundle between the 24 datapath bus drivers and the arbiter.
// Requesters drive req; the arbiter drives everything else.
interface bus_source_arbiter_if #(
    parameter int NREQ = 24,
    parameter int CNTW = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic [4:0]      bus_sel;
    logic            bus_valid;
    logic            preempt;
    logic [CNTW-1:0] hold_cnt;

    modport master (
        output req,
        input  grant, bus_sel, bus_valid, preempt, hold_cnt
    );

    modport slave (
        input  req,
        output grant, bus_sel, bus_valid, preempt, hold_cnt
    );
endinterface

// File: rtl/bus_source_arbiter.sv
// Round-robin owner of the shared 32-bit datapath bus: one-hot grant plus encoder select code,
// a one-cycle dead bus between owners, and hold-limit preemption of a monopolising owner.
module bus_source_arbiter #(
    parameter int NREQ     = 24,
    parameter int HOLD_MAX = 15,
    parameter int CNTW     = 4
) (
    input  logic                 clock,
    input  logic                 clear,
    bus_source_arbiter_if.slave  bus
);
    localparam int SELW = 5;
    localparam logic [CNTW-1:0] HOLD_SAT = (HOLD_MAX == 0) ? {CNTW{1'b1}} : CNTW'(HOLD_MAX);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [SELW-1:0] bus_sel_q, bus_sel_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic            bus_valid_q, bus_valid_d;
    logic            preempt_q, preempt_d;
    logic [CNTW-1:0] hold_cnt_q, hold_cnt_d;

    logic            win_found;
    logic [SELW-1:0] win_idx;
    logic [SELW-1:0] scan_idx;
    logic            owner_req;
    logic            other_req;

    // Search starts just past the last owner, so the ex-owner is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            scan_idx = SELW'((int'(ptr_q) + i) % NREQ);
            if (!win_found && bus.req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign owner_req = |(bus.req & grant_q);
    assign other_req = |(bus.req & ~grant_q);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        bus_sel_d   = bus_sel_q;
        bus_valid_d = bus_valid_q;
        preempt_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        ptr_d       = ptr_q;
        unique case (state_q)
            IDLE, GAP: begin
                if (win_found) begin
                    state_d     = GRANT;
                    grant_d     = ONE_HOT0 << win_idx;
                    bus_sel_d   = win_idx;
                    bus_valid_d = 1'b1;
                    hold_cnt_d  = CNTW'(1);
                    ptr_d       = win_idx;
                end else begin
                    state_d     = IDLE;
                    grant_d     = '0;
                    bus_sel_d   = '0;
                    bus_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                end
            end
            GRANT: begin
                // A voluntary release takes precedence over a coinciding hold-limit preemption.
                if (!owner_req || (HOLD_MAX != 0 && hold_cnt_q == HOLD_SAT && other_req)) begin
                    state_d     = GAP;
                    grant_d     = '0;
                    bus_sel_d   = '0;
                    bus_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    preempt_d   = owner_req;
                end else if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d  = hold_cnt_q + CNTW'(1);
                end
            end
            default: begin
                state_d     = IDLE;
                grant_d     = '0;
                bus_sel_d   = '0;
                bus_valid_d = 1'b0;
                hold_cnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            bus_sel_q   <= '0;
            bus_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
            hold_cnt_q  <= '0;
            ptr_q       <= SELW'(NREQ - 1);
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            bus_sel_q   <= bus_sel_d;
            bus_valid_q <= bus_valid_d;
            preempt_q   <= preempt_d;
            hold_cnt_q  <= hold_cnt_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.bus_sel   = bus_sel_q;
    assign bus.bus_valid = bus_valid_q;
    assign bus.preempt   = preempt_q;
    assign bus.hold_cnt  = hold_cnt_q;
endmodule
